// File: rtl/ir_pkg.sv
// -----------------------------------------------------------------------------
// ir_pkg
// Shared definitions for the IR code-playback path: the carrier generator
// state type, the default carrier value width, and the nominal system clock.
// -----------------------------------------------------------------------------
package ir_pkg;

  // Nominal system clock in MHz, shared with the controller and delay timer.
  localparam int CLK_MHZ = 8;

  // Default width of the carrier half-period compare value.
  localparam int PWM_BITS_DEFAULT = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FORCED
  } e_carrier_state;

endpackage : ir_pkg

// File: rtl/carrier_prescaler.sv
// -----------------------------------------------------------------------------
// carrier_prescaler
// Divides the system clock into carrier count ticks: one tick every PRESCALE
// clocks while enabled. Clear holds the divider at zero so the first tick
// after release lands exactly PRESCALE clocks later.
//
// Ports:
//   clock_in  - system clock
//   reset_in  - asynchronous active-high reset
//   enable_i  - count while high
//   clear_i   - synchronous clear to zero (wins over enable)
//   tick_o    - high for the clock in which the divider is at its last step
// -----------------------------------------------------------------------------
module carrier_prescaler #(
  parameter int PRESCALE      = 1,
  parameter int PRESCALE_BITS = 4
) (
  input  logic clock_in,
  input  logic reset_in,
  input  logic enable_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam logic [PRESCALE_BITS-1:0] LAST = PRESCALE_BITS'(PRESCALE - 1);

  logic [PRESCALE_BITS-1:0] pre_q;
  logic [PRESCALE_BITS-1:0] pre_d;

  always_comb begin
    // NOTE: every variable driven here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    pre_d = pre_q;
    if (clear_i) begin
      pre_d = '0;
    end else if (enable_i) begin
      pre_d = (pre_q == LAST) ? '0 : pre_q + PRESCALE_BITS'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, and the reset
  // is in the sensitivity list so it acts without waiting for a clock edge.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  // With PRESCALE=1 LAST is zero and the divider never leaves zero, so every
  // enabled clock is a tick.
  assign tick_o = enable_i && !clear_i && (pre_q == LAST);

endmodule : carrier_prescaler

// File: rtl/ir_carrier_pwm.sv
// -----------------------------------------------------------------------------
// ir_carrier_pwm
// IR LED carrier generator. A carrier half-period value is written over a
// level strobe / one-cycle ack handshake; while enabled the LED drive toggles
// every (value+1)*PRESCALE clocks starting with a mark. A forced mode drives
// the LED constantly high. Values written while running are held in a shadow
// register and take effect at the next period boundary (low->high toggle).
//
// Ports:
//   clock_in          - system clock
//   reset_in          - asynchronous active-high reset
//   pwm_enable_in     - run modulated carrier while high
//   pwm_forced_in     - constant-high output while high (beats enable)
//   pwm_wr_strobe_in  - write request level; captured on its rising edge
//   pwm_value_in      - carrier half-period value, sampled at capture
//   pwm_wr_ack_out    - one-cycle acknowledge, the cycle after capture
//   pwm_out           - registered LED drive
//   pwm_active_out    - high while running or forced
// -----------------------------------------------------------------------------
module ir_carrier_pwm
  import ir_pkg::*;
#(
  parameter int PWM_BITS      = PWM_BITS_DEFAULT,
  parameter int PRESCALE      = 1,
  parameter int PRESCALE_BITS = 4
) (
  input  logic                clock_in,
  input  logic                reset_in,
  input  logic                pwm_enable_in,
  input  logic                pwm_forced_in,
  input  logic                pwm_wr_strobe_in,
  input  logic [PWM_BITS-1:0] pwm_value_in,
  output logic                pwm_wr_ack_out,
  output logic                pwm_out,
  output logic                pwm_active_out
);

  e_carrier_state state_q, state_d;

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] active_q, active_d;
  logic [PWM_BITS-1:0] shadow_q, shadow_d;
  logic                pending_q, pending_d;
  logic                pwm_q, pwm_d;
  logic                strobe_q;
  logic                ack_q;

  logic capture;
  logic tick;
  logic run_stay;
  logic run_leave;
  logic half_done;
  logic boundary;

  carrier_prescaler #(
    .PRESCALE      (PRESCALE),
    .PRESCALE_BITS (PRESCALE_BITS)
  ) u_prescaler (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .enable_i (state_q == S_RUN),
    .clear_i  (state_q != S_RUN),
    .tick_o   (tick)
  );

  // A held strobe captures only once; it must drop for a cycle to re-arm.
  assign capture = pwm_wr_strobe_in && !strobe_q;

  // State register.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: forced beats enable; a zero carrier value never starts
  // running, but a run already in progress continues.
  always_comb begin
    state_d = S_IDLE;
    if (pwm_forced_in) begin
      state_d = S_FORCED;
    end else if (pwm_enable_in && (state_q == S_RUN || active_q != '0)) begin
      state_d = S_RUN;
    end
  end

  assign run_stay  = (state_q == S_RUN) && (state_d == S_RUN);
  assign run_leave = (state_q == S_RUN) && (state_d != S_RUN);
  assign half_done = run_stay && tick && (cnt_q == active_q);
  // A half period ending while low is the low->high toggle, i.e. a new period.
  assign boundary  = half_done && !pwm_q;

  // Output logic: the LED drive is computed from the next state so that the
  // first cycle in S_RUN already shows the mark.
  always_comb begin
    pwm_d = 1'b0;
    unique case (state_d)
      S_FORCED: pwm_d = 1'b1;
      S_RUN:    pwm_d = (state_q != S_RUN) ? 1'b1 : (pwm_q ^ half_done);
      default:  pwm_d = 1'b0;
    endcase
    pwm_active_out = (state_q == S_RUN) || (state_q == S_FORCED);
  end

  // Datapath: half-period counter and carrier value registers.
  always_comb begin
    cnt_d     = '0;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;

    if (run_stay) begin
      cnt_d = cnt_q;
      if (tick) begin
        cnt_d = (cnt_q == active_q) ? '0 : cnt_q + PWM_BITS'(1);
      end
    end

    if ((boundary || run_leave) && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end

    // Ordered after the reload so a capture coinciding with a period
    // boundary keeps pending set with the new value in the shadow.
    if (capture) begin
      if (state_q == S_RUN) begin
        shadow_d  = pwm_value_in;
        pending_d = 1'b1;
      end else begin
        active_d = pwm_value_in;
      end
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      cnt_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      pwm_q     <= 1'b0;
      strobe_q  <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      pwm_q     <= pwm_d;
      strobe_q  <= pwm_wr_strobe_in;
      ack_q     <= capture;
    end
  end

  assign pwm_out        = pwm_q;
  assign pwm_wr_ack_out = ack_q;

endmodule : ir_carrier_pwm

// File: tb/tb_ir_carrier_pwm.sv
// -----------------------------------------------------------------------------
// tb_ir_carrier_pwm
// Drives two carrier generators (PRESCALE=1 and PRESCALE=3) with the same
// stimulus and compares both against a timeline model: the output is high
// for the first (value+1)*PRESCALE clocks of each period and low for the
// next, with value changes applied at period starts.
// -----------------------------------------------------------------------------
module tb_ir_carrier_pwm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       fo  = 1'b0;
  logic       stb = 1'b0;
  logic [7:0] val = '0;

  logic ack1, out1, act1;
  logic ack3, out3, act3;

  ir_carrier_pwm #(.PWM_BITS(8), .PRESCALE(1), .PRESCALE_BITS(4)) u_dut (
    .clock_in         (clk),
    .reset_in         (rst),
    .pwm_enable_in    (en),
    .pwm_forced_in    (fo),
    .pwm_wr_strobe_in (stb),
    .pwm_value_in     (val),
    .pwm_wr_ack_out   (ack1),
    .pwm_out          (out1),
    .pwm_active_out   (act1)
  );

  ir_carrier_pwm #(.PWM_BITS(8), .PRESCALE(3), .PRESCALE_BITS(4)) u_dut3 (
    .clock_in         (clk),
    .reset_in         (rst),
    .pwm_enable_in    (en),
    .pwm_forced_in    (fo),
    .pwm_wr_strobe_in (stb),
    .pwm_value_in     (val),
    .pwm_wr_ack_out   (ack3),
    .pwm_out          (out3),
    .pwm_active_out   (act3)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Mode codes: 0 off, 1 carrier running, 2 constant high.
  typedef struct {
    int mode;
    int value;      // value governing the current period
    int next_value; // value waiting for the next period start
    bit waiting;
    int elapsed;    // clocks since the current period started
    bit out;
    bit ack;
    bit prev_strobe;
    int p;
  } mdl_t;

  function automatic mdl_t mreset(input int p);
    mdl_t m;
    m.mode = 0; m.value = 0; m.next_value = 0; m.waiting = 0;
    m.elapsed = 0; m.out = 0; m.ack = 0; m.prev_strobe = 0; m.p = p;
    return m;
  endfunction

  function automatic mdl_t step(input mdl_t m, input bit e, input bit f, input bit s, input int v);
    mdl_t n = m;
    int   nxt;
    bit   cap;
    int   half;
    cap = s && !m.prev_strobe;
    n.prev_strobe = s;
    n.ack = cap;
    if (f) nxt = 2;
    else if (e && (m.mode == 1 || m.value != 0)) nxt = 1;
    else nxt = 0;
    half = (m.value + 1) * m.p;
    if (m.mode == 1 && nxt == 1) begin
      n.elapsed = m.elapsed + 1;
      if (n.elapsed == 2 * half) begin
        n.elapsed = 0;
        if (m.waiting) begin n.value = m.next_value; n.waiting = 0; end
      end
    end else if (m.mode == 1 && m.waiting) begin
      n.value = m.next_value; n.waiting = 0;
    end
    if (nxt == 1 && m.mode != 1) n.elapsed = 0;
    if (cap) begin
      if (m.mode == 1) begin n.next_value = v; n.waiting = 1; end
      else n.value = v;
    end
    n.mode = nxt;
    n.out = (nxt == 1) ? (n.elapsed < (n.value + 1) * m.p) : (nxt == 2);
    return n;
  endfunction

  mdl_t m1 = mreset(1);
  mdl_t m3 = mreset(3);

  // Toggle-interval and ack tracking on the PRESCALE=1 instance.
  int cyc      = 0;
  int last_tog = -1;
  int intervals[$];
  int ack_cnt  = 0;
  bit prev_out = 0;
  bit rose     = 0;

  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      m1 = mreset(1);
      m3 = mreset(3);
    end else begin
      m1 = step(m1, en, fo, stb, int'(val));
      m3 = step(m3, en, fo, stb, int'(val));
    end
    @(negedge clk);
    cyc++;
    check("out_p1", out1, m1.out);
    check("ack_p1", ack1, m1.ack);
    check("act_p1", act1, m1.mode != 0);
    check("out_p3", out3, m3.out);
    check("ack_p3", ack3, m3.ack);
    check("act_p3", act3, m3.mode != 0);
    rose = out1 && !prev_out;
    if (out1 != prev_out) begin
      if (last_tog >= 0) intervals.push_back(cyc - last_tog);
      last_tog = cyc;
    end
    prev_out = out1;
    if (ack1) ack_cnt++;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic write(input int v);
    stb = 1'b1;
    val = 8'(v);
    cycle();
    stb = 1'b0;
    cycle();
  endtask

  task automatic wait_rise(input int budget, input string tag);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (rose) begin seen = 1; break; end
    end
    check(tag, seen, 1);
  endtask

  initial begin
    // Reset state.
    rst = 1'b1;
    run(3);
    @(negedge clk);
    rst = 1'b0;
    run(2);

    // Value 104 written while idle, then enable: mark first, 105-clock halves.
    write(104);
    intervals.delete();
    last_tog = -1;
    en = 1'b1;
    run(450);
    check("t1_ntog", intervals.size() >= 3, 1);
    for (int i = 0; i < 3 && i < intervals.size(); i++)
      check("t1_half", intervals[i], 105);

    // Write 69 early in a high phase: current period finishes, then 70-clock halves.
    wait_rise(300, "t2_rise_timeout");
    intervals.delete();
    ack_cnt = 0;
    write(69);
    run(600);
    check("t2_ack_once", ack_cnt, 1);
    check("t2_ntog", intervals.size() >= 4, 1);
    if (intervals.size() >= 4) begin
      check("t2_old_high", intervals[0], 105);
      check("t2_old_low",  intervals[1], 105);
      check("t2_new_high", intervals[2], 70);
      check("t2_new_low",  intervals[3], 70);
    end

    // Held strobe: one capture per rising edge of the strobe.
    en = 1'b0;
    run(3);
    ack_cnt = 0;
    stb = 1'b1;
    val = 8'd50;
    run(5);
    stb = 1'b0;
    run(1);
    check("t3_held_one_ack", ack_cnt, 1);
    stb = 1'b1;
    val = 8'd60;
    run(1);
    stb = 1'b0;
    run(3);
    check("t3_second_ack", ack_cnt, 2);

    // Forced with enable, then drop forced: carrier at value 60, mark first.
    fo = 1'b1;
    en = 1'b1;
    run(20);
    fo = 1'b0;
    run(300);

    // Zero value with enable: stays off.
    en = 1'b0;
    run(2);
    write(0);
    en = 1'b1;
    run(30);

    // Asynchronous reset mid-high phase with ack high.
    en = 1'b0;
    run(2);
    write(30);
    en = 1'b1;
    run(10);
    stb = 1'b1;
    val = 8'd77;
    cycle();
    stb = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_out_p1", out1, 0);
    check("rst_ack_p1", ack1, 0);
    check("rst_act_p1", act1, 0);
    check("rst_out_p3", out3, 0);
    check("rst_ack_p3", ack3, 0);
    check("rst_act_p3", act3, 0);
    m1 = mreset(1);
    m3 = mreset(3);
    prev_out = 0;
    run(3);
    @(negedge clk);
    rst = 1'b0;
    run(2);
    run(20); // enable still high, value cleared by reset: stays off

    // Randomized traffic.
    en = 1'b0;
    fo = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 39) == 0) en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 79) == 0) fo = ($urandom_range(0, 3) == 0);
      stb = ($urandom_range(0, 5) == 0);
      val = 8'($urandom_range(0, 15));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ir_carrier_pwm
